// File: rtl/jtsdram_pass_ctrl.sv
// Multi-pass program/verify scheduler for the JTSDRAM checker: sequences passes,
// rotates per-bank shuffle keys and the data LFSR, counts results, guards phases with a watchdog.
module jtsdram_pass_ctrl #(
  parameter int PASSES = 0,
  parameter int TOUT_W = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        prog_start,
  input  logic        prog_done,
  output logic        rd_start,
  input  logic [3:0]  ba_done,
  input  logic        bad,
  output logic [4:0]  ba0_key,
  output logic [4:0]  ba1_key,
  output logic [4:0]  ba2_key,
  output logic [4:0]  ba3_key,
  output logic [15:0] data_ref,
  output logic        busy,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt,
  output logic        timeout,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE, PROG_GO, PROG_WAIT, RD_GO, RD_WAIT, NEXT, HALT
  } state_t;

  state_t            state_q, state_d;
  logic [TOUT_W-1:0] wd_q, wd_d, wd_inc;
  logic              wd_full;
  logic              first_q, first_d;
  logic [3:0]        mask_q, mask_d;
  logic              bad_q, bad_d;
  logic [15:0]       pass_cnt_q, pass_cnt_d, pass_inc;
  logic [15:0]       fail_cnt_q, fail_cnt_d, fail_inc;
  logic              timeout_q, timeout_d;
  logic [15:0]       data_ref_q, data_ref_d;
  logic [3:0][4:0]   key_q, key_d;
  logic              rd_all;

  // Handshake: prog_start/rd_start are one-cycle pulses; prog_done/ba_done are levels
  // that are ignored on the first wait cycle so a level left over from the last pass is not taken.
  assign wd_inc   = wd_q + 1'b1;
  assign wd_full  = &wd_inc;
  assign rd_all   = ((mask_q | ba_done) == 4'hF);
  assign pass_inc = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
  assign fail_inc = (fail_cnt_q == 16'hFFFF) ? fail_cnt_q : fail_cnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    first_d    = 1'b0;
    mask_d     = mask_q;
    bad_d      = bad_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    timeout_d  = timeout_q;
    data_ref_d = data_ref_q;
    key_d      = key_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = PROG_GO;
          pass_cnt_d = 16'd0;
          fail_cnt_d = 16'd0;
          timeout_d  = 1'b0;
          bad_d      = 1'b0;
        end
      end
      PROG_GO: begin
        state_d = PROG_WAIT;
        wd_d    = '0;
        first_d = 1'b1;
      end
      PROG_WAIT: begin
        wd_d = wd_inc;
        if (!first_q && prog_done) begin
          state_d = RD_GO;
        end else if (wd_full) begin
          state_d    = HALT;
          timeout_d  = 1'b1;
          fail_cnt_d = fail_inc;
        end
      end
      RD_GO: begin
        state_d = RD_WAIT;
        wd_d    = '0;
        first_d = 1'b1;
        mask_d  = 4'h0;
        bad_d   = 1'b0;
      end
      RD_WAIT: begin
        wd_d = wd_inc;
        if (bad) bad_d = 1'b1;
        if (!first_q) mask_d = mask_q | ba_done;
        // Completion is checked before the watchdog so a finishing pass never times out.
        if (!first_q && rd_all) begin
          state_d = NEXT;
        end else if (wd_full) begin
          state_d    = HALT;
          timeout_d  = 1'b1;
          fail_cnt_d = fail_inc;
        end
      end
      NEXT: begin
        pass_cnt_d = pass_inc;
        if (bad_q) fail_cnt_d = fail_inc;
        for (int n = 0; n < 4; n++) key_d[n] = key_q[n] + 5'(2 * n + 1);
        data_ref_d = {1'b0, data_ref_q[15:1]} ^ (data_ref_q[0] ? 16'hB400 : 16'h0000);
        if (PASSES != 0 && pass_inc == 16'(PASSES)) state_d = HALT;
        else if (!enable) state_d = IDLE;
        else state_d = PROG_GO;
      end
      HALT: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      first_q    <= 1'b0;
      mask_q     <= 4'h0;
      bad_q      <= 1'b0;
      pass_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
      timeout_q  <= 1'b0;
      data_ref_q <= 16'h0001;
      key_q      <= {5'd3, 5'd2, 5'd1, 5'd0};
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      first_q    <= first_d;
      mask_q     <= mask_d;
      bad_q      <= bad_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      timeout_q  <= timeout_d;
      data_ref_q <= data_ref_d;
      key_q      <= key_d;
    end
  end

  assign prog_start = (state_q == PROG_GO);
  assign rd_start   = (state_q == RD_GO);
  assign busy       = (state_q != IDLE) && (state_q != HALT);
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign timeout    = timeout_q;
  assign data_ref   = data_ref_q;
  assign ba0_key    = key_q[0];
  assign ba1_key    = key_q[1];
  assign ba2_key    = key_q[2];
  assign ba3_key    = key_q[3];
  assign dbg_state  = state_q;

endmodule
